// File: rtl/lif_spike_encoder_pkg.sv
// Shared lif cell definitions: cell state width and the named cell state encodings.
// Cell i of a packed state bus occupies bits [CELL_W*i +: CELL_W].
package lif_spike_encoder_pkg;
  localparam int CELL_W = 4;

  typedef logic [CELL_W-1:0] cell_t;

  localparam cell_t ST_QUIET = 4'b0000;
  localparam cell_t ST_N     = 4'b1000;
  localparam cell_t ST_E     = 4'b0100;
  localparam cell_t ST_S     = 4'b0010;
  localparam cell_t ST_W     = 4'b0001;
  localparam cell_t ST_HV    = 4'b1010;
  localparam cell_t ST_VH    = 4'b0101;
endpackage

// File: rtl/lif_spike_encoder_if.sv
// Event stream towards the chip output mux: valid/ready with (cell index, state) payload.
interface lif_spike_encoder_if #(
  parameter int IDX_W = 3
) ();
  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [3:0]       evt_state;

  modport master (output evt_valid, evt_idx, evt_state, input evt_ready);
  modport slave  (input evt_valid, evt_idx, evt_state, output evt_ready);
endinterface

// File: rtl/lif_spike_encoder_evt_fifo.sv
// Show-ahead event FIFO; head is read combinationally from registered storage.
module lif_evt_fifo #(
  parameter int W     = 7,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    do_pop;

  // Extra pointer bit distinguishes full from empty; level is their difference.
  assign level  = wr_ptr - rd_ptr;
  assign full   = (level == (AW+1)'(DEPTH));
  assign empty  = (level == '0);
  assign do_pop = pop && !empty;
  assign rdata  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/lif_spike_encoder.sv
// Detects nonzero state changes on a row of lif cells, parks them in a per-cell pending
// bitmap, and drains them in fixed index priority through a small FIFO onto a stream.
module lif_spike_encoder
  import lif_spike_encoder_pkg::*;
#(
  parameter int NUM_CELLS  = 8,
  parameter int IDX_W      = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [CELL_W*NUM_CELLS-1:0]   cell_state,
  lif_spike_encoder_if.master           evt,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              event_count,
  output logic                          overflow
);
  logic [NUM_CELLS-1:0][CELL_W-1:0] cur, prev_state, pending_state;
  logic [NUM_CELLS-1:0]             pending, new_evt;
  logic [IDX_W-1:0]                 cand;
  logic                             push, pop, full, empty;
  logic [IDX_W+CELL_W-1:0]          head;

  assign cur = cell_state;

  always_comb begin
    for (int i = 0; i < NUM_CELLS; i++)
      new_evt[i] = enable && (cur[i] != ST_QUIET) && (cur[i] != prev_state[i]);
  end

  // Lowest set pending bit wins; walk downwards so the last hit is the lowest index.
  always_comb begin
    cand = '0;
    for (int i = NUM_CELLS-1; i >= 0; i--)
      if (pending[i]) cand = IDX_W'(i);
  end

  assign pop  = evt.evt_valid && evt.evt_ready;
  assign push = (|pending) && (!full || pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_state    <= '0;
      pending       <= '0;
      pending_state <= '0;
      event_count   <= '0;
      overflow      <= 1'b0;
    end else begin
      if (enable) prev_state <= cur;
      if (push && event_count != '1) event_count <= event_count + 1'b1;
      for (int i = 0; i < NUM_CELLS; i++) begin
        if (new_evt[i]) begin
          // A re-raise on the cell being pushed this cycle is a fresh event, not a merge.
          pending[i]       <= 1'b1;
          pending_state[i] <= cur[i];
          if (pending[i] && !(push && cand == IDX_W'(i))) overflow <= 1'b1;
        end else if (push && cand == IDX_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

  lif_evt_fifo #(
    .W     (IDX_W + CELL_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata ({cand, pending_state[cand]}),
    .pop   (pop),
    .rdata (head),
    .level (fifo_level),
    .full  (full),
    .empty (empty)
  );

  // Storage is not reset, so the payload is forced to zero while the FIFO is empty.
  assign evt.evt_valid = !empty;
  assign evt.evt_idx   = empty ? '0 : head[IDX_W+CELL_W-1:CELL_W];
  assign evt.evt_state = empty ? '0 : head[CELL_W-1:0];
endmodule

// File: tb/tb_lif_spike_encoder.sv
// Directed bench for lif_spike_encoder with hand-computed expectations.
module tb_lif_spike_encoder;
  import lif_spike_encoder_pkg::*;

  localparam int NC = 8, IW = 3, FD = 4, CW = 8;

  logic          clk = 1'b0;
  logic          reset, enable;
  logic [NC*4-1:0] cell_state;
  logic [2:0]    fifo_level;
  logic [CW-1:0] event_count;
  logic          overflow;

  lif_spike_encoder_if #(.IDX_W(IW)) evt ();

  lif_spike_encoder #(
    .NUM_CELLS(NC), .IDX_W(IW), .FIFO_DEPTH(FD), .CNT_W(CW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .cell_state  (cell_state),
    .evt         (evt),
    .fifo_level  (fifo_level),
    .event_count (event_count),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_cell(int i, logic [3:0] v);
    cell_state[4*i +: 4] = v;
  endtask

  task automatic chk_head(string tag, logic v, int idx, int st);
    chk({tag, ".valid"}, 32'(evt.evt_valid), 32'(v));
    chk({tag, ".idx"},   32'(evt.evt_idx),   32'(idx));
    chk({tag, ".state"}, 32'(evt.evt_state), 32'(st));
  endtask

  int          exp_idx [5] = '{1, 2, 3, 4, 5};
  logic [3:0]  exp_st  [5] = '{4'h2, 4'h3, 4'h4, 4'hA, 4'h6};
  int          exp_lvl [5] = '{4, 4, 3, 2, 1};

  initial begin
    // Reset with junk on the cell bus
    reset = 1'b1; enable = 1'b1; evt.evt_ready = 1'b0;
    cell_state = $urandom;
    step(2);
    chk_head("rst", 1'b0, 0, 0);
    chk("rst.level", 32'(fifo_level), 0);
    chk("rst.count", 32'(event_count), 0);
    chk("rst.ovf",   32'(overflow), 0);
    cell_state = '0; reset = 1'b0;
    step();

    // Single event on cell 3: pending after 1 edge, visible after 2
    evt.evt_ready = 1'b1;
    set_cell(3, ST_E);
    step();
    chk("single.lat1", 32'(evt.evt_valid), 0);
    step();
    chk_head("single", 1'b1, 3, 4'b0100);
    chk("single.count", 32'(event_count), 1);
    step(4);
    chk("single.hold.valid", 32'(evt.evt_valid), 0);
    chk("single.hold.count", 32'(event_count), 1);

    // Simultaneous events drain in index order
    set_cell(5, ST_W); set_cell(1, ST_N); set_cell(6, ST_VH);
    step(2);
    chk_head("simul0", 1'b1, 1, 4'b1000);
    step();
    chk_head("simul1", 1'b1, 5, 4'b0001);
    step();
    chk_head("simul2", 1'b1, 6, 4'b0101);
    step();
    chk("simul.empty", 32'(evt.evt_valid), 0);
    chk("simul.count", 32'(event_count), 4);

    // Backpressure: six events, four fit, two stay pending
    cell_state = '0; reset = 1'b1; step(2); reset = 1'b0;
    evt.evt_ready = 1'b0;
    for (int i = 0; i < 6; i++) set_cell(i, 4'(i + 1));
    step(6);
    chk("bp.level", 32'(fifo_level), 4);
    chk("bp.count", 32'(event_count), 4);
    chk("bp.ovf0",  32'(overflow), 0);
    chk_head("bp.head", 1'b1, 0, 4'h1);
    set_cell(4, ST_HV);
    step();
    chk("bp.ovf1",   32'(overflow), 1);
    chk("bp.count2", 32'(event_count), 4);

    // Release: first two edges pop and push together while full
    evt.evt_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("drain%0d.level", k), 32'(fifo_level), 32'(exp_lvl[k]));
      chk_head($sformatf("drain%0d", k), 1'b1, exp_idx[k], 32'(exp_st[k]));
    end
    step();
    chk("drain.empty", 32'(evt.evt_valid), 0);
    chk("drain.count", 32'(event_count), 6);

    // Enable gating
    enable = 1'b0;
    for (int i = 0; i < NC; i++) set_cell(i, 4'h7);
    step(4);
    chk("gate.valid", 32'(evt.evt_valid), 0);
    chk("gate.count", 32'(event_count), 6);
    chk("gate.level", 32'(fifo_level), 0);

    // Saturation: 300 toggles on cell 0 plus the backlog from re-enabling
    enable = 1'b1;
    for (int k = 0; k < 300; k++) begin
      set_cell(0, k[0] ? ST_N : ST_S);
      step();
    end
    step(12);
    chk("sat.count", 32'(event_count), 255);
    for (int k = 0; k < 10; k++) begin
      set_cell(0, k[0] ? ST_E : ST_W);
      step();
    end
    step(4);
    chk("sat.hold",  32'(event_count), 255);
    chk("sat.ovf",   32'(overflow), 1);
    chk("sat.empty", 32'(evt.evt_valid), 0);

    // Reset clears sticky state
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst2.ovf",   32'(overflow), 0);
    chk("rst2.count", 32'(event_count), 0);
    chk("rst2.level", 32'(fifo_level), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
